// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the weighted round-robin bus scheduler.
// Holds the FSM encoding and the packet header decode.
package bus_sched_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;
    localparam int PKT_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_e;

    // Destination ID sits in the top byte of a pw-bit packet.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt, input int pw);
        return pkt[pw-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bus_rr_sched_rr_pick.sv
// Rotating-priority picker: first requester after `last`, with `last` itself
// considered at the very end of the scan.
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] gnt_id,
    output logic          any
);

    logic [LW-1:0] idx;

    always_comb begin
        idx    = '0;
        gnt_id = last;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = LW'((int'(last) + k) % N);
            if (!any && req[idx]) begin
                any    = 1'b1;
                gnt_id = idx;
            end
        end
    end

endmodule

// File: rtl/bus_rr_sched.sv
// Weighted round-robin bus scheduler: pops one packet from the granted device
// FIFO and pushes it to the device(s) decoded from its header byte.
module bus_rr_sched
    import bus_sched_pkg::*;
#(
    parameter int             drvrs     = 4,
    parameter int             pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT,
    parameter int             weight_w  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    input  logic                       cfg_we,
    input  logic [$clog2(drvrs)-1:0]   cfg_id,
    input  logic [weight_w-1:0]        cfg_weight,
    output logic [$clog2(drvrs)-1:0]   gnt_id,
    output logic                       busy,
    output logic                       drop,
    output logic [15:0]                drop_cnt
);

    localparam int IW = $clog2(drvrs);

    state_e                              state_r, state_nxt;
    logic [IW-1:0]                       gnt_r, ptr_r, last_w, rr_gnt, sel_g, ptr_nxt;
    logic                                rr_any, sel_en, regrant;
    logic [weight_w-1:0]                 burst_r, burst_nxt, wsel;
    logic [drvrs-1:0][weight_w-1:0]      weight_r;
    logic [drvrs-1:0][pckg_sz-1:0]       slices;
    logic [pckg_sz-1:0]                  pkt_r;
    logic [ID_W-1:0]                     dst;

    assign slices = D_pop;

    // ptr_r is the highest-priority device; the picker wants the one before it.
    assign last_w = (ptr_r == '0) ? IW'(drvrs - 1) : ptr_r - 1'b1;

    rr_pick #(.N(drvrs)) u_pick (
        .req    (pndng),
        .last   (last_w),
        .gnt_id (rr_gnt),
        .any    (rr_any)
    );

    assign sel_en  = (state_r != POP) && rr_any;
    assign regrant = (burst_r != '0) && pndng[gnt_r];
    assign sel_g   = regrant ? gnt_r : rr_gnt;
    assign wsel    = weight_r[sel_g];
    assign ptr_nxt = (sel_g == IW'(drvrs - 1)) ? '0 : sel_g + 1'b1;

    // A zero weight behaves as one: the burst counter loads as zero either way.
    always_comb begin
        burst_nxt = '0;
        if (regrant)
            burst_nxt = burst_r - 1'b1;
        else if (wsel != '0)
            burst_nxt = wsel - 1'b1;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state_r)
            IDLE:    state_nxt = sel_en ? POP : IDLE;
            POP:     state_nxt = PUSH;
            PUSH:    state_nxt = sel_en ? POP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            gnt_r    <= '0;
            ptr_r    <= '0;
            burst_r  <= '0;
            pkt_r    <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < drvrs; i++)
                weight_r[i] <= weight_w'(1);
        end else begin
            state_r <= state_nxt;
            if (sel_en) begin
                gnt_r   <= sel_g;
                ptr_r   <= ptr_nxt;
                burst_r <= burst_nxt;
            end
            if (state_r == POP)
                pkt_r <= slices[gnt_r];
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (cfg_we && int'(cfg_id) < drvrs)
                weight_r[cfg_id] <= cfg_weight;
        end
    end

    assign dst    = dest_of(PKT_MAX'(pkt_r), pckg_sz);
    assign gnt_id = gnt_r;
    assign busy   = (state_r != IDLE);

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        pop    = '0;
        push   = '0;
        D_push = '0;
        drop   = 1'b0;
        if (state_r == POP)
            pop[gnt_r] = 1'b1;
        if (state_r == PUSH) begin
            D_push = pkt_r;
            if (dst < ID_W'(drvrs)) begin
                for (int i = 0; i < drvrs; i++)
                    push[i] = (dst == ID_W'(i));
            end else if (dst == broadcast) begin
                push        = '1;
                push[gnt_r] = 1'b0;
            end else begin
                drop = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed bench for bus_rr_sched: device FIFO models feed the DUT and a
// per-source scoreboard checks every push/drop cycle.
module tb_bus_rr_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] D_pop;
    logic [3:0]  pop, push;
    logic [15:0] D_push;
    logic        cfg_we;
    logic [1:0]  cfg_id;
    logic [3:0]  cfg_weight;
    logic [1:0]  gnt_id;
    logic        busy, drop;
    logic [15:0] drop_cnt;

    bus_rr_sched dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .cfg_we(cfg_we), .cfg_id(cfg_id),
        .cfg_weight(cfg_weight), .gnt_id(gnt_id), .busy(busy), .drop(drop),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] fq[4][$];
    logic [20:0] eq[4][$];
    int          pops[$];
    int          pop_cyc[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, pend = 0, cur_src = 0;
    bit          pend_v = 0, seen_push = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] exp_of(input int src, input logic [15:0] pkt);
        logic [3:0] p;
        logic       d;
        p = 4'h0;
        d = 1'b0;
        if (pkt[15:8] < 8'd4)        p = 4'h1 << pkt[9:8];
        else if (pkt[15:8] == 8'hFF) p = 4'hF & ~(4'h1 << src);
        else                         d = 1'b1;
        return {p, pkt, d};
    endfunction

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            pndng[i]          = (fq[i].size() != 0);
            D_pop[i*16 +: 16] = (fq[i].size() != 0) ? fq[i][0] : 16'h0;
        end
    endtask

    task automatic send(input int dev, input logic [15:0] pkt);
        fq[dev].push_back(pkt);
        eq[dev].push_back(exp_of(dev, pkt));
        refresh();
    endtask

    // One cycle: retire the FIFO head popped last cycle, then observe outputs.
    task automatic step();
        logic [20:0] e;
        @(negedge clk);
        cyc++;
        if (pend_v) begin
            if (fq[pend].size() != 0) void'(fq[pend].pop_front());
            pend_v = 0;
        end
        chk("pop_push_excl", {31'd0, (|pop && |push)}, 32'd0);
        chk("pop_onehot", {31'd0, $onehot0(pop)}, 32'd1);
        for (int i = 0; i < 4; i++)
            if (pop[i]) begin
                pend = i; pend_v = 1; cur_src = i;
                pops.push_back(i);
                pop_cyc.push_back(cyc);
            end
        if (|push || drop) begin
            seen_push = 1;
            if (eq[cur_src].size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                e = eq[cur_src].pop_front();
                chk("sb_out", {11'd0, push, D_push, drop}, {11'd0, e});
            end
        end
        refresh();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || pend_v || fq[0].size() != 0 || fq[1].size() != 0 ||
                fq[2].size() != 0 || fq[3].size() != 0) && n < 400) begin
            step();
            n++;
        end
        chk("idle_timeout", {31'd0, n < 400}, 32'd1);
        chk("sb_drained", eq[0].size() + eq[1].size() + eq[2].size() + eq[3].size(), 0);
    endtask

    initial begin
        int exp2[5] = '{0, 1, 2, 3, 0};
        int exp3[8] = '{0, 0, 0, 2, 0, 0, 0, 2};
        int n;
        reset = 1'b1; cfg_we = 1'b0; cfg_id = '0; cfg_weight = '0;
        pndng = '0; D_pop = '0;
        repeat (2) @(negedge clk);
        chk("rst_pop", {28'd0, pop}, 0);
        chk("rst_push", {28'd0, push}, 0);
        chk("rst_dpush", {16'd0, D_push}, 0);
        chk("rst_gnt", {30'd0, gnt_id}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_drop", {31'd0, drop}, 0);
        chk("rst_cnt", {16'd0, drop_cnt}, 0);
        reset = 1'b0;

        // single device, unicast
        send(1, 16'h02AB);
        step();
        chk("t1_pop", {28'd0, pop}, 32'b0010);
        chk("t1_gnt", {30'd0, gnt_id}, 1);
        step();
        chk("t1_push", {28'd0, push}, 32'b0100);
        chk("t1_dpush", {16'd0, D_push}, 32'h02AB);
        step();
        chk("t1_busy", {31'd0, busy}, 0);

        // all four pending: rotation from dev0, one pop per two cycles
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        pops.delete(); pop_cyc.delete();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++)
                send(i, {8'((i + 1) % 4), 8'(i * 16 + j)});
        wait_idle();
        chk("t2_npops", pops.size(), 8);
        for (int k = 0; k < 5; k++) chk("t2_order", pops[k], exp2[k]);
        for (int k = 0; k < 4; k++) chk("t2_gap", pop_cyc[k+1] - pop_cyc[k], 2);

        // weight 3 on dev0 against dev2
        cfg_we = 1'b1; cfg_id = 2'd0; cfg_weight = 4'd3;
        step();
        cfg_we = 1'b0;
        pops.delete();
        for (int j = 0; j < 6; j++) send(0, {8'h01, 8'(j)});
        for (int j = 0; j < 2; j++) send(2, {8'h03, 8'(j)});
        wait_idle();
        chk("t3_npops", pops.size(), 8);
        for (int k = 0; k < 8; k++) chk("t3_order", pops[k], exp3[k]);

        // broadcast and self-send
        send(2, 16'hFF55);
        wait_idle();
        send(3, 16'h0366);
        wait_idle();
        chk("t4_drop_cnt", {16'd0, drop_cnt}, 0);

        // invalid destination drops and saturation
        send(3, 16'h0711);
        wait_idle();
        chk("t5_cnt1", {16'd0, drop_cnt}, 1);
        chk("t5_drop_low", {31'd0, drop}, 0);
        for (int j = 0; j < 9; j++) send(j % 4, {8'h40, 8'(j)});
        wait_idle();
        chk("t5_cnt10", {16'd0, drop_cnt}, 10);
        force dut.drop_cnt = 16'hFFFD;
        step();
        release dut.drop_cnt;
        for (int j = 0; j < 4; j++) send(1, {8'h80, 8'(j)});
        wait_idle();
        chk("t5_sat", {16'd0, drop_cnt}, 32'hFFFF);

        // reset while in PUSH, then weights back to 1
        seen_push = 0;
        send(1, 16'h0022);
        n = 0;
        while (!seen_push && n < 20) begin step(); n++; end
        chk("t6_reached_push", {31'd0, seen_push}, 1);
        reset = 1'b1;
        #1;
        chk("t6_push", {28'd0, push}, 0);
        chk("t6_pop", {28'd0, pop}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_dpush", {16'd0, D_push}, 0);
        @(negedge clk);
        reset = 1'b0;
        pend_v = 0;
        pops.delete();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++)
                send(i, {8'(3 - i), 8'(j)});
        wait_idle();
        chk("t6_npops", pops.size(), 8);
        for (int k = 0; k < 4; k++) chk("t6_order", pops[k], k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
